// File: rtl/csr_pkg.sv
// ---------------------------------------------------------------------------
// csr_pkg
// Constants shared by the AXI4-Lite CSR responder and its byte-lane merge:
// the AXI response codes, the register map indices and the data width.
// Register 0 is written as COMMAND and read back as STATUS.
// ---------------------------------------------------------------------------
package csr_pkg;

  localparam int unsigned CSR_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned REG_COMMAND = 0;
  localparam int unsigned REG_STATUS  = 0;
  localparam int unsigned REG_R1      = 1;
  localparam int unsigned REG_R2      = 2;
  localparam int unsigned REG_R3      = 3;
  localparam int unsigned REG_R4      = 4;
  localparam int unsigned REG_R5      = 5;
  localparam int unsigned REG_R6      = 6;
  localparam int unsigned REG_R7      = 7;

endpackage

// File: rtl/csr_strb_merge.sv
// ---------------------------------------------------------------------------
// csr_strb_merge
// Combinational byte-lane merge: each byte of the result comes from wdata
// when its strobe bit is set, otherwise from the current register value.
// Ports:
//   old_data  in  32  current register contents
//   wdata     in  32  host write data
//   wstrb     in  4   byte strobes
//   merged    out 32  merged value to store
// ---------------------------------------------------------------------------
module csr_strb_merge
  import csr_pkg::*;
(
  input  logic [CSR_DATA_W-1:0]   old_data,
  input  logic [CSR_DATA_W-1:0]   wdata,
  input  logic [CSR_DATA_W/8-1:0] wstrb,
  output logic [CSR_DATA_W-1:0]   merged
);

  // Select each byte lane from new or old data.
  always_comb begin
    merged = old_data;
    for (int b = 0; b < CSR_DATA_W / 8; b++) begin
      merged[8*b +: 8] = wstrb[b] ? wdata[8*b +: 8] : old_data[8*b +: 8];
    end
  end

endmodule

// File: rtl/axil_csr_slave.sv
// ---------------------------------------------------------------------------
// axil_csr_slave
// AXI4-Lite responder exposing NUM_REGS 32-bit registers. Host writes land in
// csr_out (byte-strobed); host reads return the core-driven csr_in values.
// Register i lives at byte address 4*i; addr[1:0] is ignored. Indices at or
// beyond NUM_REGS answer SLVERR (writes dropped, reads return zero).
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   s_axi_csrs_aw*/w*/b*   write address, data and response channels
//   s_axi_csrs_ar*/r*      read address and data channels
//   csr_out                host-written registers, reg i at [32*i+31:32*i]
//   csr_in                 core readback values, same packing
//   csr_wr_pulse           one-cycle commit strobe per register
//                          (present only when CSR_WR_PULSE_EN is defined)
// ---------------------------------------------------------------------------
module axil_csr_slave
  import csr_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 12
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [ADDR_W-1:0]          s_axi_csrs_awaddr,
  input  logic                       s_axi_csrs_awvalid,
  output logic                       s_axi_csrs_awready,
  input  logic [31:0]                s_axi_csrs_wdata,
  input  logic [3:0]                 s_axi_csrs_wstrb,
  input  logic                       s_axi_csrs_wvalid,
  output logic                       s_axi_csrs_wready,
  output logic [1:0]                 s_axi_csrs_bresp,
  output logic                       s_axi_csrs_bvalid,
  input  logic                       s_axi_csrs_bready,
  input  logic [ADDR_W-1:0]          s_axi_csrs_araddr,
  input  logic                       s_axi_csrs_arvalid,
  output logic                       s_axi_csrs_arready,
  output logic [31:0]                s_axi_csrs_rdata,
  output logic [1:0]                 s_axi_csrs_rresp,
  output logic                       s_axi_csrs_rvalid,
  input  logic                       s_axi_csrs_rready,
  output logic [NUM_REGS*32-1:0]     csr_out,
  input  logic [NUM_REGS*32-1:0]     csr_in
`ifdef CSR_WR_PULSE_EN
  ,
  output logic [NUM_REGS-1:0]        csr_wr_pulse
`endif
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic                  aw_hold_r, w_hold_r, bvalid_r, rvalid_r;
  logic [ADDR_W-1:0]     awaddr_r;
  logic [31:0]           wdata_r, rdata_r;
  logic [3:0]            wstrb_r;
  logic [1:0]            bresp_r, rresp_r;
  logic [31:0]           regs_r   [NUM_REGS];
  logic [31:0]           csr_in_s [NUM_REGS];

  logic                  aw_hs_s, w_hs_s, ar_hs_s, commit_s, wr_ok_s, rd_ok_s;
  logic [ADDR_W-1:0]     cur_addr_s;
  logic [31:0]           cur_wdata_s, old_s, merged_s, rd_word_s;
  logic [3:0]            cur_wstrb_s;
  logic [ADDR_W-3:0]     wr_idx_s, rd_idx_s;
  logic                  unused_s;

  // Byte offset bits carry no information for word registers.
  assign unused_s = ^{s_axi_csrs_awaddr[1:0], s_axi_csrs_araddr[1:0], awaddr_r[1:0]};

  // Readies are combinational so AW/W/AR can be taken in the cycle they appear.
  assign s_axi_csrs_awready = resetn & ~aw_hold_r & ~bvalid_r;
  assign s_axi_csrs_wready  = resetn & ~w_hold_r & ~bvalid_r;
  assign s_axi_csrs_arready = resetn & ~rvalid_r;
  assign s_axi_csrs_bvalid  = bvalid_r;
  assign s_axi_csrs_bresp   = bresp_r;
  assign s_axi_csrs_rvalid  = rvalid_r;
  assign s_axi_csrs_rresp   = rresp_r;
  assign s_axi_csrs_rdata   = rdata_r;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_pack
    assign csr_out[32*i +: 32] = regs_r[i];
    assign csr_in_s[i]         = csr_in[32*i +: 32];
  end

  // Handshakes, commit condition and address decode for both channels.
  always_comb begin
    aw_hs_s     = s_axi_csrs_awvalid & s_axi_csrs_awready;
    w_hs_s      = s_axi_csrs_wvalid & s_axi_csrs_wready;
    ar_hs_s     = s_axi_csrs_arvalid & s_axi_csrs_arready;
    // A commit needs both halves, each either held or arriving now.
    commit_s    = (aw_hold_r | aw_hs_s) & (w_hold_r | w_hs_s);
    cur_addr_s  = aw_hold_r ? awaddr_r : s_axi_csrs_awaddr;
    cur_wdata_s = w_hold_r ? wdata_r : s_axi_csrs_wdata;
    cur_wstrb_s = w_hold_r ? wstrb_r : s_axi_csrs_wstrb;
    wr_idx_s    = cur_addr_s[ADDR_W-1:2];
    rd_idx_s    = s_axi_csrs_araddr[ADDR_W-1:2];
    wr_ok_s     = 32'(wr_idx_s) < 32'(NUM_REGS);
    rd_ok_s     = 32'(rd_idx_s) < 32'(NUM_REGS);
    old_s       = wr_ok_s ? regs_r[wr_idx_s[IDX_W-1:0]] : 32'h0000_0000;
    rd_word_s   = rd_ok_s ? csr_in_s[rd_idx_s[IDX_W-1:0]] : 32'h0000_0000;
  end

  csr_strb_merge u_merge (
    .old_data (old_s),
    .wdata    (cur_wdata_s),
    .wstrb    (cur_wstrb_s),
    .merged   (merged_s)
  );

  // Write channel: hold AW/W independently, commit when both are present.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      aw_hold_r <= 1'b0;
      w_hold_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bresp_r   <= RESP_OKAY;
      awaddr_r  <= {ADDR_W{1'b0}};
      wdata_r   <= 32'h0000_0000;
      wstrb_r   <= 4'h0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= 32'h0000_0000;
      end
    end else if (commit_s) begin
      if (wr_ok_s) begin
        regs_r[wr_idx_s[IDX_W-1:0]] <= merged_s;
      end
      bvalid_r  <= 1'b1;
      bresp_r   <= wr_ok_s ? RESP_OKAY : RESP_SLVERR;
      aw_hold_r <= 1'b0;
      w_hold_r  <= 1'b0;
    end else begin
      if (aw_hs_s) begin
        aw_hold_r <= 1'b1;
        awaddr_r  <= s_axi_csrs_awaddr;
      end
      if (w_hs_s) begin
        w_hold_r <= 1'b1;
        wdata_r  <= s_axi_csrs_wdata;
        wstrb_r  <= s_axi_csrs_wstrb;
      end
      if (bvalid_r && s_axi_csrs_bready) begin
        bvalid_r <= 1'b0;
      end
    end
  end

  // Read channel: capture csr_in on AR accept, hold until R handshake.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rvalid_r <= 1'b0;
      rdata_r  <= 32'h0000_0000;
      rresp_r  <= RESP_OKAY;
    end else if (ar_hs_s) begin
      rvalid_r <= 1'b1;
      rdata_r  <= rd_word_s;
      rresp_r  <= rd_ok_s ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_r && s_axi_csrs_rready) begin
      rvalid_r <= 1'b0;
    end
  end

`ifdef CSR_WR_PULSE_EN
  // One-cycle strobe for the register committed at the previous edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      csr_wr_pulse <= {NUM_REGS{1'b0}};
    end else begin
      csr_wr_pulse <= {NUM_REGS{1'b0}};
      if (commit_s && wr_ok_s) begin
        csr_wr_pulse[wr_idx_s[IDX_W-1:0]] <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: doc/axil_csr_slave.md
Name: axil_csr_slave

Overview:
AXI4-Lite responder exposing NUM_REGS 32-bit control/status registers to the host. It is the slave end of the s_axi_csrs interface that the host drives to write register addresses and the command word, and that it polls for the done bit. Written values drive csr_out to the accelerator core. Reads return core-driven csr_in values, so register 0 reads back as STATUS while being written as COMMAND. It sits between the interconnect and the RSA core inside the project wrapper.

Parameters:
NUM_REGS, 8, number of 32-bit registers; byte address of register i is 4*i.
ADDR_W, 12, AXI-Lite address width.

Ports:
clk  in  1  system clock
resetn  in  1  synchronous reset, active-low; sampled on the rising edge of clk
s_axi_csrs_awaddr  in  ADDR_W  write address
s_axi_csrs_awvalid  in  1  write address valid
s_axi_csrs_awready  out  1  write address ready
s_axi_csrs_wdata  in  32  write data
s_axi_csrs_wstrb  in  4  byte strobes
s_axi_csrs_wvalid  in  1  write data valid
s_axi_csrs_wready  out  1  write data ready
s_axi_csrs_bresp  out  2  write response
s_axi_csrs_bvalid  out  1  write response valid
s_axi_csrs_bready  in  1  write response ready
s_axi_csrs_araddr  in  ADDR_W  read address
s_axi_csrs_arvalid  in  1  read address valid
s_axi_csrs_arready  out  1  read address ready
s_axi_csrs_rdata  out  32  read data
s_axi_csrs_rresp  out  2  read response
s_axi_csrs_rvalid  out  1  read data valid
s_axi_csrs_rready  in  1  read data ready
csr_out  out  NUM_REGS*32  host-written registers; register i occupies bits [32*i+31:32*i]
csr_in  in  NUM_REGS*32  core-driven readback values, same packing

Behaviour:
- Reset (resetn=0 at a clock edge): csr_out=0, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, aw_hold=0, w_hold=0.
- All ready outputs are forced to 0 while resetn=0.
- Write channel state: aw_hold and w_hold flags plus the bvalid register.
  - awready = !aw_hold & !bvalid.
  - wready = !w_hold & !bvalid.
  - AW and W are accepted independently, in either order and with any gap between them; the address and data/strobe are latched into holding registers.
- Write commit: at the edge where the address is available (held, or handshaking this cycle) and the data is also available (held, or handshaking this cycle):
  - the register update happens, byte lane b written only when wstrb[b]=1;
  - bvalid is set to 1 and both hold flags are cleared.
  - Latency: AW and W both handshaked in cycle 0 gives csr_out updated and bvalid=1 in cycle 1.
- bvalid stays 1 until a bvalid&bready edge. No new AW or W is accepted before then.
- Read channel: arready = !rvalid.
  - At the arvalid&arready edge: rdata is loaded from csr_in[index], rvalid is set to 1, latency 1.
  - rdata and rresp stay stable until the rvalid&rready edge, then rvalid returns to 0.
  - Back-to-back reads give one transfer per 2 cycles.
- Decode: index = addr[ADDR_W-1:2]; addr[1:0] is ignored (unaligned addresses are word-aligned).
  - index >= NUM_REGS gives resp 2'b10 (SLVERR). A write is discarded; a read returns rdata=0.
  - Otherwise resp is 2'b00.
- Read and write channels operate concurrently. A read of register i in the same cycle as a write commit to register i returns csr_in (the read path never sees csr_out).
- Reset mid-transaction: all in-flight state is discarded, with no response issued. csr_out is cleared even if a commit would have occurred at that edge; reset has priority.

Optional Feature:
CSR_WR_PULSE_EN
- Defined: adds output csr_wr_pulse [NUM_REGS-1:0], reset 0. Bit i is high for exactly the one cycle after a commit to register i (aligned with the bvalid rise), including commits with wstrb=0. SLVERR writes produce no pulse. The core uses it to start on a COMMAND write without edge detection.
- Undefined: the port and its logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package csr_pkg holds:
  - constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - register index constants REG_COMMAND=0, REG_STATUS=0 and REG_R1..REG_R7=1..7;
  - constant CSR_DATA_W=32.
- One natural sub-module, csr_strb_merge: combinational byte-lane merge of old value, wdata and wstrb. The top holds all sequential logic.

Test Plan:
- Write addr 0x18, wdata=0x10, wstrb=4'hF, AW and W in the same cycle -> csr_out[6]=0x00000010 one cycle later, bvalid=1, bresp=0.
- csr_out[2]=0xAABBCCDD, then write addr 0x08, wdata=0x11223344, wstrb=4'b0101 -> csr_out[2]=0xAA22CC44.
- W presented 3 cycles before AW, then bready held low 5 cycles -> wready drops after the W accept, commit only after AW, bvalid held 5 cycles with awready=wready=0 throughout.
- csr_in[0]=0x1, read addr 0x00, rready delayed 2 cycles -> rvalid from cycle 1 with rdata=0x00000001 stable until handshake; write 0x1 to addr 0 still sets csr_out[0]=0x1 independently.
- Write addr 0x40 and read addr 0x40 (NUM_REGS=8) -> bresp=2'b10, rresp=2'b10, rdata=0, all csr_out unchanged.
- resetn low for 1 cycle after AW is accepted but before W -> aw_hold cleared, csr_out=0, a subsequent full write to addr 0x04 completes normally with OKAY.
